// File: rtl/jtag_cmd_seq.sv
// JTAG command sequencer: loads IR/DR FIFOs from host commands and an
// upstream stream, kicks the shift engine and tracks its busy handshake.
// Ports: clk/rst_n; host cmd (start, cmd_ready, cmd_mode, cmd_instr,
// cmd_nwords); stream (data_in, data_valid, data_ready); engine (op, work,
// busy); FIFOs (wdata_*, wr_*, full_*, usedw_*); status (done, err).
// Build option: JTAG_CMD_SEQ_TIMEOUT_EN adds an engine handshake timeout.
module jtag_cmd_seq #(
    parameter int DATA_INSTRUCTION = 6,
    parameter int DATA_FIFO = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_WORDS = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int UW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(MAX_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_mode,
    input  logic [DATA_INSTRUCTION-1:0] cmd_instr,
    input  logic [CW-1:0]               cmd_nwords,
    input  logic [DATA_FIFO-1:0]        data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        op,
    output logic                        work,
    input  logic                        busy,
    output logic [DATA_INSTRUCTION-1:0] wdata_instruction,
    output logic                        wr_instruction,
    input  logic                        full_instruction,
    input  logic [UW-1:0]               usedw_instruction,
    output logic [DATA_FIFO-1:0]        wdata_data,
    output logic                        wr_data,
    input  logic                        full_data,
    input  logic [UW-1:0]               usedw_data,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FREE,
        WR_INSTR,
        WR_DATA,
        KICK,
        WAIT_ACK,
        WAIT_END,
        DONE
    } state_t;

    localparam logic [CW-1:0] MAX_W = CW'(MAX_WORDS);

    state_t                      state;
    state_t                      state_d;
    logic [1:0]                  mode_q;
    logic [DATA_INSTRUCTION-1:0] instr_q;
    logic [CW-1:0]               nwords_q;
    logic [CW-1:0]               rem_q;
    logic                        op_q;
    logic                        err_q;
    logic                        accept;
    logic                        illegal;
    logic                        reload;
    logic                        timeout_hit;

    assign accept  = start && (state == IDLE);
    assign illegal = (cmd_mode == 2'b00)
                  || (cmd_mode[1] && (cmd_nwords == '0))
                  || (cmd_nwords > MAX_W);

    assign cmd_ready         = (state == IDLE);
    assign data_ready        = (state == WR_DATA) && !full_data;
    assign wr_data           = data_valid && data_ready;
    assign wdata_data        = data_in;
    assign wr_instruction    = (state == WR_INSTR) && !full_instruction;
    assign wdata_instruction = instr_q;
    assign work              = (state == KICK);
    assign op                = op_q;
    assign done              = (state == DONE);
    assign err               = err_q;

    // IR phase of an IR+DR command falls through to the data load.
    assign reload = (state == WAIT_END) && (state_d == WR_DATA);

`ifdef JTAG_CMD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic          waiting;

    assign waiting     = (state == WAIT_ACK) || (state == WAIT_END);
    assign timeout_hit = waiting && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state == KICK) begin
            cnt_q <= '0;
        end else if (waiting && !timeout_hit) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

    // FIFO levels are informational; flow control uses the full flags.
    logic unused_usedw;
    assign unused_usedw = ^{usedw_instruction, usedw_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:      if (accept && !illegal) state_d = WAIT_FREE;
            WAIT_FREE: if (!busy) state_d = mode_q[0] ? WR_INSTR : WR_DATA;
            WR_INSTR:  if (!full_instruction) state_d = KICK;
            WR_DATA:   if (wr_data && (rem_q == CW'(1))) state_d = KICK;
            KICK:      state_d = WAIT_ACK;
            WAIT_ACK:  if (busy) state_d = WAIT_END;
            WAIT_END: begin
                if (!busy) begin
                    if (!op_q && (mode_q == 2'b11)) state_d = WR_DATA;
                    else state_d = DONE;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= '0;
            instr_q  <= '0;
            nwords_q <= '0;
            rem_q    <= '0;
            op_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (accept && illegal) || timeout_hit;
            if (accept) begin
                mode_q   <= cmd_mode;
                instr_q  <= cmd_instr;
                nwords_q <= cmd_nwords;
            end
            if (accept) rem_q <= cmd_nwords;
            else if (reload) rem_q <= nwords_q;
            else if (wr_data) rem_q <= rem_q - CW'(1);
            // Phase is fixed on entry to KICK and held until the next kick.
            if ((state_d == KICK) && (state != KICK)) begin
                op_q <= (state == WR_DATA);
            end
        end
    end

endmodule
